// File: rtl/mcc_pkg.sv
// Shared types and constants for the sliced add sequencer.
// Optional subtract mode is enabled by MCC_ADD_SEQUENCER_SUB_EN.
package mcc_pkg;

    localparam int DEF_WIDTH = 64;
    localparam int DEF_SLICE = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int beat_w(input int nbeats);
        int w;
        w = $clog2(nbeats);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/mcc_slice_adder.sv
// SLICE-bit combinational adder built from rippled 4-bit Manchester
// carry-chain groups (generate / propagate / kill per bit).
import mcc_pkg::*;

module mcc_slice_adder #(
    parameter int SLICE = DEF_SLICE
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             ci,
    output logic [SLICE-1:0] s,
    output logic             co
);

    localparam int NGRP = SLICE / 4;

    logic [SLICE-1:0] g;
    logic [SLICE-1:0] p;
    logic [SLICE:0]   c;

    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c    = '0;
        c[0] = ci;
        for (int k = 0; k < NGRP; k++) begin
            for (int i = 0; i < 4; i++) begin
                c[4*k+i+1] = g[4*k+i] | (p[4*k+i] & c[4*k+i]);
            end
        end
        s  = p ^ c[SLICE-1:0];
        co = c[SLICE];
    end

endmodule

// File: rtl/mcc_add_sequencer.sv
// Multi-cycle adder: one SLICE-bit slice reused over WIDTH/SLICE beats.
// Define MCC_ADD_SEQUENCER_SUB_EN to add the sub port (A - B mode).
import mcc_pkg::*;

module mcc_add_sequencer #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SLICE = DEF_SLICE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef MCC_ADD_SEQUENCER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int NBEATS = WIDTH / SLICE;
    localparam int BW     = beat_w(NBEATS);
    localparam logic [BW-1:0] LAST = BW'(NBEATS - 1);

    state_t           state_q, state_d;
    logic [BW-1:0]    beat_q, beat_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             inv_b;

    logic [SLICE-1:0] sl_a;
    logic [SLICE-1:0] sl_b;
    logic [SLICE-1:0] sl_s;
    logic             sl_co;
    int               off;

`ifdef MCC_ADD_SEQUENCER_SUB_EN
    logic sub_q, sub_d;
    assign inv_b = sub_q;
`else
    assign inv_b = 1'b0;
`endif

    assign off  = int'(beat_q) * SLICE;
    assign sl_a = a_q[off +: SLICE];
    assign sl_b = b_q[off +: SLICE] ^ {SLICE{inv_b}};

    mcc_slice_adder #(
        .SLICE (SLICE)
    ) u_slice (
        .a  (sl_a),
        .b  (sl_b),
        .ci (carry_q),
        .s  (sl_s),
        .co (sl_co)
    );

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef MCC_ADD_SEQUENCER_SUB_EN
        sub_d   = sub_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    beat_d  = '0;
                    state_d = RUN;
`ifdef MCC_ADD_SEQUENCER_SUB_EN
                    sub_d   = sub;
                    // two's-complement subtract: ~B plus a forced carry-in
                    carry_d = sub ? 1'b1 : cin;
`else
                    carry_d = cin;
`endif
                end
            end
            RUN: begin
                sum_d[off +: SLICE] = sl_s;
                carry_d             = sl_co;
                if (beat_q == LAST) begin
                    beat_d  = '0;
                    cout_d  = sl_co;
                    state_d = DONE;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            beat_q  <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef MCC_ADD_SEQUENCER_SUB_EN
            sub_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
`ifdef MCC_ADD_SEQUENCER_SUB_EN
            sub_q   <= sub_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_mcc_add_sequencer.sv
// Scoreboard bench for mcc_add_sequencer (default 64/16 configuration).
// Subtract vectors run only when MCC_ADD_SEQUENCER_SUB_EN is defined.
module tb_mcc_add_sequencer;

    localparam int W  = 64;
    localparam int NB = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] sum;
    logic         cout;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_acc = 0;
    logic was_v = 1'b0;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        int           acc;
    } exp_t;

    exp_t q[$];

    mcc_add_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef MCC_ADD_SEQUENCER_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        total++;
        bad++;
        $display("FAIL %s: got timeout expected event", nm);
    endtask

    // Monitor: latency on rising out_valid, result on handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            was_v = 1'b0;
        end else begin
            if (out_valid && !was_v) begin
                if (q.size() == 0)
                    chk("spurious_out_valid", W'(out_valid), '0);
                else
                    chk("latency", W'(cyc - q[0].acc), W'(NB));
            end
            if (out_valid && out_ready && q.size() > 0) begin
                chk("sum", sum, q[0].s);
                chk("cout", W'(cout), W'(q[0].c));
                void'(q.pop_front());
            end
            was_v = out_valid;
        end
    end

    task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic ci, input logic sb,
                        input logic [W-1:0] es, input logic ec,
                        input bit push, input int gap,
                        output int tries);
        bit h;
        h = 1'b0;
        tries = 0;
        in_valid = 1'b1;
        a = av;
        b = bv;
        cin = ci;
        sub = sb;
        for (int i = 0; i < 60 && !h; i++) begin
            @(negedge clk);
            h = in_ready;
            @(posedge clk);
            #1;
            tries++;
        end
        if (!h) begin
            timeout("accept");
        end else begin
            if (push) q.push_back('{es, ec, cyc});
            if (gap > 0) chk("accept_spacing", W'(cyc - last_acc), W'(gap));
            last_acc = cyc;
        end
        a = ~av;
        b = ~bv;
        cin = ~ci;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && q.size() != 0; i++) @(posedge clk);
        #1;
        if (q.size() != 0) timeout("drain");
    endtask

    initial begin
        int t;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_in_ready", W'(in_ready), W'(1));
        chk("rst_out_valid", W'(out_valid), '0);
        chk("rst_sum", sum, '0);
        chk("rst_cout", W'(cout), '0);
        #15 rst_n = 1'b1;

        // carry crosses slice 0 -> 1; first edge after reset accepts
        send(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0,
             64'h0000_0000_0001_0000, 1'b0, 1'b1, 0, t);
        chk("first_accept_tries", W'(t), W'(1));
        in_valid = 1'b0;
        drain();

        // carry ripples through all four slices into cout
        send('1, '0, 1'b1, 1'b0, '0, 1'b1, 1'b1, 0, t);
        in_valid = 1'b0;
        drain();

        // back-pressure: hold DONE for 10 cycles
        out_ready = 1'b0;
        send(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b0,
             64'h2222_2222_2222_2211, 1'b0, 1'b1, 0, t);
        in_valid = 1'b0;
        for (int i = 0; i < 20 && !out_valid; i++) begin
            @(posedge clk);
            #1;
        end
        if (!out_valid) timeout("bp_out_valid");
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("bp_sum", sum, 64'h2222_2222_2222_2211);
            chk("bp_cout", W'(cout), '0);
            chk("bp_in_ready", W'(in_ready), '0);
            chk("bp_out_valid", W'(out_valid), W'(1));
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_in_ready", W'(in_ready), W'(1));
        chk("bp_release_out_valid", W'(out_valid), '0);

        // reset mid-operation at beat 2
        send(64'hDEAD_BEEF_0000_0001, 64'h1, 1'b0, 1'b0,
             '0, 1'b0, 1'b0, 0, t);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", W'(in_ready), W'(1));
        chk("mid_rst_out_valid", W'(out_valid), '0);
        chk("mid_rst_sum", sum, '0);
        chk("mid_rst_cout", W'(cout), '0);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            chk("post_rst_no_valid", W'(out_valid), '0);
        end
        send(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 1'b0,
             64'h1, 1'b1, 1'b1, 0, t);
        in_valid = 1'b0;
        drain();

        // back-to-back with in_valid held high
        send(64'h1, 64'h2, 1'b0, 1'b0, 64'h3, 1'b0, 1'b1, 0, t);
        send(64'hFFFF_FFFF_0000_0000, 64'h0000_0001_0000_0000, 1'b0, 1'b0,
             '0, 1'b1, 1'b1, NB + 2, t);
        send(64'h00FF_00FF_00FF_00FF, 64'hFF01_FF01_FF01_FF01, 1'b0, 1'b0,
             64'h0001_0001_0001_0000, 1'b1, 1'b1, NB + 2, t);
        in_valid = 1'b0;
        drain();

`ifdef MCC_ADD_SEQUENCER_SUB_EN
        send(64'h5, 64'h7, 1'b0, 1'b1,
             64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1, 0, t);
        in_valid = 1'b0;
        drain();
        send(64'h7, 64'h5, 1'b1, 1'b1, 64'h2, 1'b1, 1'b1, 0, t);
        in_valid = 1'b0;
        drain();
`endif

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mcc_add_sequencer.md
MCC_ADD_SEQUENCER -- requirements
Module: mcc_add_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 64, as the operand and result width; legal values are multiples of SLICE and at least SLICE.
REQ-002 The block SHALL have parameter SLICE, default 16, as the width of the shared carry-chain adder slice; legal values are multiples of 4.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port in_valid, input, 1 bit: request carries valid operands.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block can accept a request.
REQ-007 The block SHALL have port a, input, WIDTH bits: operand A.
REQ-008 The block SHALL have port b, input, WIDTH bits: operand B.
REQ-009 The block SHALL have port cin, input, 1 bit: carry into bit 0.
REQ-010 The block SHALL have port out_valid, output, 1 bit: the result is held valid.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-012 The block SHALL have port sum, output, WIDTH bits: the result.
REQ-013 The block SHALL have port cout, output, 1 bit: carry out of bit WIDTH-1.

Function
REQ-014 The block SHALL contain one SLICE-bit adder slice, reused over NBEATS = WIDTH/SLICE cycles.
REQ-015 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-016 In IDLE, in_ready SHALL be 1; in RUN and DONE, in_ready SHALL be 0.
REQ-017 On in_valid && in_ready, the block SHALL:
- latch a, b and cin;
- clear the beat counter;
- go to RUN.
REQ-018 In RUN, each cycle SHALL:
- add slice[beat] of A and B with the carry register;
- write the slice sum to sum[beat*SLICE +: SLICE];
- update the carry register;
- increment the beat counter.
REQ-019 After beat NBEATS-1, the block SHALL go to DONE and set out_valid=1 and cout to the final carry.
REQ-020 Latency SHALL be NBEATS cycles from the accept edge to out_valid=1; the default configuration gives 4 cycles.
REQ-021 In DONE, sum, cout and out_valid SHALL hold stable until out_ready=1.
REQ-022 On out_valid && out_ready, the block SHALL return to IDLE on the next edge and clear out_valid.
REQ-023 A request presented in the same cycle as a DONE handshake SHALL NOT be accepted; it is accepted at the earliest one cycle later, in IDLE.
REQ-024 Operand inputs SHALL be ignored outside the accept cycle.
REQ-025 Carry wrap-around SHALL be handled as follows:
- carry out of slice k feeds slice k+1 only;
- the carry out of the last slice goes only to cout, never back to slice 0.
REQ-026 WIDTH == SLICE SHALL be legal, giving NBEATS=1 and a latency of 1 cycle.

Reset
REQ-027 While rst_n=0, the block SHALL immediately force:
- FSM to IDLE;
- in_ready=1;
- out_valid=0;
- sum=0;
- cout=0;
- beat counter=0;
- carry register=0.
REQ-028 Reset asserted in RUN or DONE SHALL discard the operation, and no out_valid SHALL follow.
REQ-029 The first request after rst_n deasserts SHALL be acceptable on the first rising clk edge.

Configuration
REQ-030 With MCC_ADD_SEQUENCER_SUB_EN defined, the block SHALL have an extra input port sub (1 bit), latched at accept.
REQ-031 With MCC_ADD_SEQUENCER_SUB_EN defined and sub=1, the block SHALL:
- invert B at the slice input;
- force the initial carry to 1, ignoring cin;
- yield sum = A - B, with cout=1 meaning no borrow.
REQ-032 Without MCC_ADD_SEQUENCER_SUB_EN, the sub port SHALL be absent and the block SHALL always compute A + B + cin.

Structure
REQ-033 A shared package mcc_pkg SHALL hold:
- the FSM state enum (IDLE/RUN/DONE);
- the default WIDTH and SLICE constants;
- the beat-counter width function, clog2 of NBEATS, minimum 1.
REQ-034 The adder datapath SHALL be the sub-module mcc_slice_adder, a SLICE-bit combinational ripple of 4-bit Manchester carry-chain groups.
REQ-035 The sequencer module SHALL hold only the FSM, the counter, the carry register and the operand/result registers.

Verification
REQ-036 The bench SHALL cover: a=0x0000_0000_0000_FFFF, b=1, cin=0 -> sum=0x0000_0000_0001_0000, cout=0, out_valid 4 cycles after accept.
REQ-037 The bench SHALL cover: a=all-ones, b=0, cin=1 -> sum=0, cout=1, with carry crossing all four slices.
REQ-038 The bench SHALL cover back-pressure: out_ready=0 for 10 cycles in DONE -> sum and cout stable, in_ready=0 throughout; then out_ready=1 -> IDLE on the next edge.
REQ-039 The bench SHALL cover reset: rst_n pulsed low at RUN beat 2 -> outputs at reset values immediately, no out_valid, and the next request computes correctly.
REQ-040 The bench SHALL cover MCC_ADD_SEQUENCER_SUB_EN: sub=1, a=5, b=7 -> sum=0xFFFF_FFFF_FFFF_FFFE, cout=0; sub=1, a=7, b=5 -> sum=2, cout=1.
REQ-041 The bench SHALL cover back-to-back requests with in_valid held high -> accepts spaced NBEATS+2 cycles apart when out_ready=1, and results match a reference model.
